// File: rtl/alarm_timer_sched_if.sv
// Request/status bundle between the alarm FSM / user reprogram logic and the
// shared countdown timer.
interface alarm_timer_sched_if;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       start;
  logic [1:0] interval;
  logic       cancel;
  logic       busy;
  logic       expired;
  logic [3:0] remaining;
  logic       one_hz;

  modport master (
    output reprogram, time_param_sel, time_value, start, interval, cancel,
    input  busy, expired, remaining, one_hz
  );

  modport slave (
    input  reprogram, time_param_sel, time_value, start, interval, cancel,
    output busy, expired, remaining, one_hz
  );
endinterface

// File: rtl/alarm_timer_sched.sv
// Shared anti-theft countdown timer: parameter file, one-second prescaler and
// single-interval FSM. Optional REPROG_LOCK_EN blocks parameter writes while busy.
//
// state   | meaning
// S_IDLE  | no interval running, remaining = 0
// S_COUNT | interval running, count decrements on each one_hz tick
module alarm_timer_sched #(
  parameter int TICK_DIV   = 100000000,
  parameter int DEF_ARM    = 6,
  parameter int DEF_DRIVER = 8,
  parameter int DEF_PASS   = 15,
  parameter int DEF_ALARM  = 10
) (
  input logic                clock,
  input logic                reset,
  alarm_timer_sched_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0][3:0] PARAM_DEF = {4'(DEF_ALARM), 4'(DEF_PASS),
                                           4'(DEF_DRIVER), 4'(DEF_ARM)};

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      count_q, count_d;
  logic [3:0][3:0] param_q, param_d;
  logic            expired_q, expired_d;
  logic            one_hz_q, one_hz_d;
  logic            tick;
  logic            wr_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      param_q   <= PARAM_DEF;
      expired_q <= 1'b0;
      one_hz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      param_q   <= param_d;
      expired_q <= expired_d;
      one_hz_q  <= one_hz_d;
    end
  end

`ifdef REPROG_LOCK_EN
  assign wr_en = bus.reprogram && (state_q == S_IDLE);
`else
  assign wr_en = bus.reprogram;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    param_d   = param_q;
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;

    // Intervals always load from param_q, so a same-cycle write is not seen.
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          state_d = S_COUNT;
          count_d = param_q[bus.interval];
          presc_d = '0;
        end
      end
      S_COUNT: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (bus.start) begin
          count_d = param_q[bus.interval];
          presc_d = '0;
        end else if (tick) begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_d   = S_IDLE;
            expired_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    if (wr_en) begin
      param_d[bus.time_param_sel] = (bus.time_value == 4'd0) ?
                                    PARAM_DEF[bus.time_param_sel] : bus.time_value;
    end

    one_hz_d = (presc_d == PRESC_MAX);
  end

  assign bus.busy      = (state_q == S_COUNT);
  assign bus.expired   = expired_q;
  assign bus.remaining = count_q;
  assign bus.one_hz    = one_hz_q;

endmodule

// File: tb/tb_alarm_timer_sched.sv
// Randomized + directed bench for alarm_timer_sched with a cycle-time reference
// model and an expiry scoreboard.
module tb_alarm_timer_sched;

  localparam int TD   = 4;
  localparam int D_ARM = 6, D_DRV = 8, D_PAS = 15, D_ALM = 10;
`ifdef REPROG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clock;
  logic rst_n;
  alarm_timer_sched_if bus ();

  alarm_timer_sched #(
    .TICK_DIV(TD), .DEF_ARM(D_ARM), .DEF_DRIVER(D_DRV),
    .DEF_PASS(D_PAS), .DEF_ALARM(D_ALM)
  ) dut (
    .clock(clock),
    .reset(rst_n),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: absolute cycle numbers, not register state.
  int cyc  = 0;
  int base = 0;
  int m_e  = 0;
  int m_n  = 0;
  bit m_busy = 1'b0;
  bit m_inc;
  int m_param [4];
  int exp_q [$];
  int e;

  function automatic int def_of(input int sel);
    case (sel)
      0: return D_ARM;
      1: return D_DRV;
      2: return D_PAS;
      default: return D_ALM;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_param[i] = def_of(i);
    m_busy = 1'b0;
    base   = cyc;
    exp_q.delete();
  endtask

  always @(posedge clock) begin
    if (rst_n) begin
      m_inc = m_busy;
      if (bus.cancel) begin
        if (m_inc) begin
          m_busy = 1'b0;
          void'(exp_q.pop_back());
        end
      end else if (bus.start) begin
        if (m_inc) void'(exp_q.pop_back());
        m_busy = 1'b1;
        m_e    = cyc + 1;
        m_n    = m_param[bus.interval];
        base   = cyc + 1;
        exp_q.push_back(m_e + TD * m_n);
      end else if (m_inc && (cyc + 1 == m_e + TD * m_n)) begin
        m_busy = 1'b0;
      end
      if (bus.reprogram && !(LOCK && m_inc))
        m_param[bus.time_param_sel] = (bus.time_value == 4'd0) ?
                                      def_of(int'(bus.time_param_sel)) : int'(bus.time_value);
      cyc = cyc + 1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clock) begin
    if (rst_n) begin
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("remaining", int'(bus.remaining), m_busy ? (m_n - (cyc - m_e) / TD) : 0);
      chk("one_hz", int'(bus.one_hz), int'(((cyc - base) % TD) == TD - 1));
      if (bus.expired) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL expired_spurious cyc=%0d actual=1 expected=0", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("expired_cycle", cyc, e);
        end
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL expired_missing cyc=%0d actual=0 expected_at=%0d", cyc, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.reprogram = 1'b0;
    bus.interval = 2'd0;
    bus.time_param_sel = 2'd0;
    bus.time_value = 4'd0;
  endtask

  task automatic pulse_start(input logic [1:0] iv);
    bus.start = 1'b1;
    bus.interval = iv;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic write_param(input logic [1:0] sel, input logic [3:0] val);
    bus.reprogram = 1'b1;
    bus.time_param_sel = sel;
    bus.time_value = val;
    step(1);
    bus.reprogram = 1'b0;
  endtask

  task automatic check_zero_outputs();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_expired", int'(bus.expired), 0);
    chk("rst_remaining", int'(bus.remaining), 0);
    chk("rst_one_hz", int'(bus.one_hz), 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_zero_outputs();
    model_reset();
    step(n);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    check_zero_outputs();
    @(posedge clock);
    #7;
    rst_n = 1'b1;

    // arm delay 6 s
    step(2);
    pulse_start(2'd0);
    step(30);
    // short driver delay, then restore default
    write_param(2'd1, 4'd3);
    pulse_start(2'd1);
    step(16);
    write_param(2'd1, 4'd0);
    pulse_start(2'd1);
    step(36);
    // cancel together with start
    pulse_start(2'd3);
    step(9);
    bus.cancel = 1'b1;
    bus.start  = 1'b1;
    step(1);
    clear_inputs();
    step(62);
    // restart before expiry
    pulse_start(2'd0);
    step(19);
    pulse_start(2'd1);
    step(40);
    // reprogram while running
    pulse_start(2'd2);
    step(29);
    write_param(2'd2, 4'd2);
    step(35);
    pulse_start(2'd2);
    step(64);
    // write and start in same cycle
    bus.reprogram = 1'b1;
    bus.time_param_sel = 2'd0;
    bus.time_value = 4'd1;
    bus.start = 1'b1;
    bus.interval = 2'd0;
    step(1);
    clear_inputs();
    step(30);
    pulse_start(2'd0);
    step(8);
    // reset mid-interval
    pulse_start(2'd3);
    step(6);
    do_reset(3);
    step(10);
    pulse_start(2'd2);
    step(64);

    for (int i = 0; i < 2500; i++) begin
      bus.start          = ($urandom_range(0, 39) == 0);
      bus.interval       = 2'($urandom_range(0, 3));
      bus.cancel         = ($urandom_range(0, 79) == 0);
      bus.reprogram      = ($urandom_range(0, 14) == 0);
      bus.time_param_sel = 2'($urandom_range(0, 3));
      bus.time_value     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 799) == 0) begin
        clear_inputs();
        do_reset(2);
      end else begin
        step(1);
      end
    end

    clear_inputs();
    step(70);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
